amo_sequencer: RTL and testbench

// Per-agent atomic sequencer sitting between the load-store unit's AMO issue path and the shared atomic unit.

---
 rtl/amo_sequencer.sv | 167 ++++++++++++++++
 tb/tb_amo_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/amo_sequencer.sv
// Per-agent atomic sequencer: runs one LR/SC/AMO request at a time against memory
// and one agent slot of the shared atomic unit, then returns the rd value upstream.
module amo_sequencer #(
  parameter int ID_WIDTH = 4,
  parameter bit ALU_REG  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_op,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_data,
  input  logic [ID_WIDTH-1:0] req_id,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [31:0]         rsp_data,
  output logic                rsp_err,
  output logic [ID_WIDTH-1:0] rsp_id,
  output logic                mem_rd_valid,
  input  logic                mem_rd_ready,
  output logic [31:0]         mem_rd_addr,
  input  logic                mem_rd_data_valid,
  input  logic [31:0]         mem_rd_data,
  output logic                mem_wr_valid,
  input  logic                mem_wr_ready,
  output logic [31:0]         mem_wr_addr,
  output logic [31:0]         mem_wr_data,
  output logic                set_reservation,
  output logic                clear_reservation,
  output logic [31:0]         reservation,
  input  logic                reservation_valid,
  output logic                rmw_valid,
  output logic [4:0]          op,
  output logic [31:0]         rs1,
  output logic [31:0]         rs2,
  input  logic [31:0]         rd
);

  localparam logic [4:0] AMO_LR_FN5 = 5'b00010;
  localparam logic [4:0] AMO_SC_FN5 = 5'b00011;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RD_REQ   = 4'd1,
    RD_WAIT  = 4'd2,
    LR_SET   = 4'd3,
    ALU      = 4'd4,
    ALU_HOLD = 4'd5,
    SC_CHK   = 4'd6,
    WR       = 4'd7,
    ERR      = 4'd8,
    RSP      = 4'd9
  } state_t;

  state_t              state, state_next;
  logic [31:0]         addr_q, data_q, old_q, wr_data_q, rsp_data_q;
  logic [4:0]          op_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                err_q;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_addr[1:0] != 2'b00)    state_next = ERR;
          else if (req_op == AMO_SC_FN5) state_next = SC_CHK;
          else                           state_next = RD_REQ;
        end else begin
          state_next = IDLE;
        end
      end
      RD_REQ:   state_next = mem_rd_ready ? RD_WAIT : RD_REQ;
      RD_WAIT: begin
        if (mem_rd_data_valid) state_next = (op_q == AMO_LR_FN5) ? LR_SET : ALU;
        else                   state_next = RD_WAIT;
      end
      LR_SET:   state_next = RSP;
      ALU:      state_next = ALU_REG ? ALU_HOLD : WR;
      ALU_HOLD: state_next = WR;
      SC_CHK:   state_next = reservation_valid ? WR : RSP;
      WR:       state_next = mem_wr_ready ? RSP : WR;
      ERR:      state_next = RSP;
      RSP:      state_next = rsp_ready ? IDLE : RSP;
      default:  state_next = IDLE;
    endcase
  end

  // Request latch, loaded value, write data and response value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      old_q      <= 32'd0;
      wr_data_q  <= 32'd0;
      rsp_data_q <= 32'd0;
      op_q       <= 5'd0;
      id_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            data_q     <= req_data;
            op_q       <= req_op;
            id_q       <= req_id;
            rsp_data_q <= 32'd0;
            err_q      <= (req_addr[1:0] != 2'b00);
          end
        end
        RD_WAIT: begin
          if (mem_rd_data_valid) begin
            old_q      <= mem_rd_data;
            rsp_data_q <= mem_rd_data;
          end
        end
        ALU:     wr_data_q <= rd;
        SC_CHK: begin
          wr_data_q  <= data_q;
          rsp_data_q <= {31'd0, ~reservation_valid};
        end
        default: begin
        end
      endcase
    end
  end

  // Moore decode of the state; strobes and acceptance are masked while reset is held.
  always_comb begin
    req_ready         = 1'b0;
    mem_rd_valid      = 1'b0;
    mem_wr_valid      = 1'b0;
    set_reservation   = 1'b0;
    clear_reservation = 1'b0;
    rmw_valid         = 1'b0;
    rsp_valid         = 1'b0;
    case (state)
      IDLE:    req_ready         = rst;
      RD_REQ:  mem_rd_valid      = 1'b1;
      LR_SET:  set_reservation   = rst;
      ALU:     rmw_valid         = rst;
      SC_CHK:  clear_reservation = rst;
      WR:      mem_wr_valid      = 1'b1;
      RSP:     rsp_valid         = 1'b1;
      default: req_ready         = 1'b0;
    endcase
  end

  assign mem_rd_addr = addr_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = wr_data_q;
  assign reservation = addr_q;
  assign op          = op_q;
  assign rs1         = old_q;
  assign rs2         = data_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = err_q;
  assign rsp_id      = id_q;

endmodule

// File: tb/tb_amo_sequencer.sv
// Directed bench for amo_sequencer: behavioural memory and atomic ALU around the DUT,
// one task per scenario with hand-computed expected values.
module tb_amo_sequencer;

  localparam logic [4:0] FN_ADD  = 5'b00000;
  localparam logic [4:0] FN_SWAP = 5'b00001;
  localparam logic [4:0] FN_LR   = 5'b00010;
  localparam logic [4:0] FN_SC   = 5'b00011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_ready;
  logic [4:0]  req_op = 5'd0;
  logic [31:0] req_addr = 32'd0, req_data = 32'd0;
  logic [3:0]  req_id = 4'd0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_id;
  logic        mem_rd_valid, mem_rd_ready = 1'b1, mem_rd_data_valid;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        mem_wr_valid, mem_wr_ready = 1'b1;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic        set_reservation, clear_reservation, reservation_valid = 1'b0, rmw_valid;
  logic [31:0] reservation, rs1, rs2, rd;
  logic [4:0]  op;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:255];
  int rmw_cnt = 0, set_cnt = 0, clr_cnt = 0, wr_cnt = 0, rd_cnt = 0, rsp_cnt = 0, multi_cnt = 0;
  logic [31:0] last_rs1 = 32'd0, last_res = 32'd0;

  amo_sequencer #(.ID_WIDTH(4), .ALU_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_data(req_data), .req_id(req_id),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_id(rsp_id),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data_valid(mem_rd_data_valid), .mem_rd_data(mem_rd_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data),
    .set_reservation(set_reservation), .clear_reservation(clear_reservation),
    .reservation(reservation), .reservation_valid(reservation_valid),
    .rmw_valid(rmw_valid), .op(op), .rs1(rs1), .rs2(rs2), .rd(rd)
  );

  always #5 clk = ~clk;

  // Reference atomic ALU: add for AMOADD, pass rs2 for everything else used here.
  assign rd = (op == FN_ADD) ? (rs1 + rs2) : rs2;

  // Memory model: preload under reset, read data one cycle after acceptance, writes on acceptance.
  always @(posedge clk) begin
    mem_rd_data_valid <= mem_rd_valid && mem_rd_ready && rst;
    mem_rd_data       <= mem[mem_rd_addr[9:2]];
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[8'h40] <= 32'h0000_0010;
      mem[8'h80] <= 32'h0000_0077;
      mem[8'h44] <= 32'h0000_0020;
      mem[8'h48] <= 32'h0000_0001;
    end else if (mem_wr_valid && mem_wr_ready) begin
      mem[mem_wr_addr[9:2]] <= mem_wr_data;
    end
  end

  // Event counters for strobes and handshakes.
  always @(posedge clk) begin
    if (rmw_valid) begin rmw_cnt <= rmw_cnt + 1; last_rs1 <= rs1; end
    if (set_reservation) begin set_cnt <= set_cnt + 1; last_res <= reservation; end
    if (clear_reservation) clr_cnt <= clr_cnt + 1;
    if (mem_wr_valid && mem_wr_ready) wr_cnt <= wr_cnt + 1;
    if (mem_rd_valid && mem_rd_ready) rd_cnt <= rd_cnt + 1;
    if (rsp_valid && rsp_ready) rsp_cnt <= rsp_cnt + 1;
    if ((32'(rmw_valid) + 32'(set_reservation) + 32'(clear_reservation)) > 32'd1)
      multi_cnt <= multi_cnt + 1;
  end

  task automatic send_req(input logic [4:0] o, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] id);
    @(negedge clk);
    req_op = o; req_addr = a; req_data = d; req_id = id; req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL req_ready_idle got=%b exp=1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [4:0] o, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] id, output logic [31:0] rdata, output logic err,
                         output logic [3:0] rid, output int lat);
    bit done;
    send_req(o, a, d, id);
    done = 1'b0; lat = 0;
    for (int i = 1; i <= 60 && !done; i++) begin
      @(negedge clk);
      if (rsp_valid) begin done = 1'b1; lat = i; end
    end
    checks++;
    if (!done) begin failures++; $display("FAIL rsp_timeout got=none exp=rsp_valid"); end
    rdata = rsp_data; err = rsp_err; rid = rsp_id;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rsp_valid, mem_rd_valid, mem_wr_valid, set_reservation, clear_reservation, rmw_valid} !== 6'd0) begin
      failures++; $display("FAIL reset_valids got=%b exp=000000",
        {rsp_valid, mem_rd_valid, mem_wr_valid, set_reservation, clear_reservation, rmw_valid});
    end
    checks++;
    if ({rsp_data, reservation, mem_wr_data} !== 96'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {rsp_data, reservation, mem_wr_data});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_amoadd();
    logic [31:0] r; logic e; logic [3:0] id; int lat;
    int rmw0, wr0;
    rmw0 = rmw_cnt; wr0 = wr_cnt;
    run_req(FN_ADD, 32'h100, 32'd5, 4'h3, r, e, id, lat);
    checks++; if (r !== 32'h10) begin failures++; $display("FAIL add_rsp got=%h exp=10", r); end
    checks++; if (lat != 6) begin failures++; $display("FAIL add_latency got=%0d exp=6", lat); end
    checks++; if ({e, id} !== {1'b0, 4'h3}) begin failures++; $display("FAIL add_err_id got=%b/%h exp=0/3", e, id); end
    checks++; if (mem[8'h40] !== 32'h15) begin failures++; $display("FAIL add_mem got=%h exp=15", mem[8'h40]); end
    checks++; if (rmw_cnt - rmw0 != 1) begin failures++; $display("FAIL add_rmw_pulses got=%0d exp=1", rmw_cnt - rmw0); end
    checks++; if (last_rs1 !== 32'h10) begin failures++; $display("FAIL add_rs1 got=%h exp=10", last_rs1); end
    checks++; if (wr_cnt - wr0 != 1) begin failures++; $display("FAIL add_writes got=%0d exp=1", wr_cnt - wr0); end
  endtask

  task automatic test_lr_sc();
    logic [31:0] r; logic e; logic [3:0] id; int lat;
    int set0, clr0;
    set0 = set_cnt; clr0 = clr_cnt;
    run_req(FN_LR, 32'h200, 32'd0, 4'h1, r, e, id, lat);
    checks++; if (r !== 32'h77) begin failures++; $display("FAIL lr_rsp got=%h exp=77", r); end
    checks++; if (lat != 4) begin failures++; $display("FAIL lr_latency got=%0d exp=4", lat); end
    checks++; if (set_cnt - set0 != 1) begin failures++; $display("FAIL lr_set_pulses got=%0d exp=1", set_cnt - set0); end
    checks++; if (last_res !== 32'h200) begin failures++; $display("FAIL lr_res_addr got=%h exp=200", last_res); end
    reservation_valid = 1'b1;
    run_req(FN_SC, 32'h200, 32'hAB, 4'h2, r, e, id, lat);
    reservation_valid = 1'b0;
    checks++; if (r !== 32'h0) begin failures++; $display("FAIL sc_pass_rsp got=%h exp=0", r); end
    checks++; if (lat != 3) begin failures++; $display("FAIL sc_pass_latency got=%0d exp=3", lat); end
    checks++; if (mem[8'h80] !== 32'hAB) begin failures++; $display("FAIL sc_pass_mem got=%h exp=ab", mem[8'h80]); end
    checks++; if (clr_cnt - clr0 != 1) begin failures++; $display("FAIL sc_pass_clear got=%0d exp=1", clr_cnt - clr0); end
    checks++; if (id !== 4'h2) begin failures++; $display("FAIL sc_pass_id got=%h exp=2", id); end
  endtask

  task automatic test_sc_fail();
    logic [31:0] r; logic e; logic [3:0] id; int lat;
    int clr0, wr0, rd0;
    clr0 = clr_cnt; wr0 = wr_cnt; rd0 = rd_cnt;
    run_req(FN_SC, 32'h300, 32'h55, 4'h4, r, e, id, lat);
    checks++; if (r !== 32'h1) begin failures++; $display("FAIL sc_fail_rsp got=%h exp=1", r); end
    checks++; if (lat != 2) begin failures++; $display("FAIL sc_fail_latency got=%0d exp=2", lat); end
    checks++; if ((wr_cnt - wr0) + (rd_cnt - rd0) != 0) begin failures++; $display("FAIL sc_fail_memacc got=%0d exp=0", (wr_cnt - wr0) + (rd_cnt - rd0)); end
    checks++; if (clr_cnt - clr0 != 1) begin failures++; $display("FAIL sc_fail_clear got=%0d exp=1", clr_cnt - clr0); end
  endtask

  task automatic test_misaligned();
    logic [31:0] r; logic e; logic [3:0] id; int lat;
    int act0;
    act0 = rd_cnt + wr_cnt + set_cnt + clr_cnt + rmw_cnt;
    run_req(FN_SWAP, 32'h102, 32'h99, 4'hA, r, e, id, lat);
    checks++; if ({e, r} !== {1'b1, 32'h0}) begin failures++; $display("FAIL mis_err_data got=%b/%h exp=1/0", e, r); end
    checks++; if (id !== 4'hA) begin failures++; $display("FAIL mis_id got=%h exp=a", id); end
    checks++; if (rd_cnt + wr_cnt + set_cnt + clr_cnt + rmw_cnt != act0) begin
      failures++; $display("FAIL mis_strobes got=%0d exp=%0d", rd_cnt + wr_cnt + set_cnt + clr_cnt + rmw_cnt, act0);
    end
    checks++; if (mem[8'h40] !== 32'h15) begin failures++; $display("FAIL mis_mem got=%h exp=15", mem[8'h40]); end
  endtask

  task automatic test_stalls();
    bit seen;
    mem_rd_ready = 1'b0; mem_wr_ready = 1'b0; rsp_ready = 1'b0;
    send_req(FN_ADD, 32'h110, 32'd7, 4'h5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({mem_rd_valid, mem_rd_addr} !== {1'b1, 32'h110}) begin
        failures++; $display("FAIL stall_rd got=%b/%h exp=1/110", mem_rd_valid, mem_rd_addr);
      end
    end
    mem_rd_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (mem_wr_valid) seen = 1'b1; end
    checks++; if (!seen) begin failures++; $display("FAIL stall_wr_timeout got=none exp=mem_wr_valid"); end
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({mem_wr_valid, mem_wr_addr, mem_wr_data} !== {1'b1, 32'h110, 32'h27}) begin
        failures++; $display("FAIL stall_wr got=%b/%h/%h exp=1/110/27", mem_wr_valid, mem_wr_addr, mem_wr_data);
      end
    end
    mem_wr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
    checks++; if (!seen) begin failures++; $display("FAIL stall_rsp_timeout got=none exp=rsp_valid"); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_data, rsp_id, rsp_err} !== {1'b1, 32'h20, 4'h5, 1'b0}) begin
        failures++; $display("FAIL stall_rsp got=%b/%h/%h/%b exp=1/20/5/0", rsp_valid, rsp_data, rsp_id, rsp_err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL stall_release got=%b exp=01", {rsp_valid, req_ready}); end
    checks++; if (mem[8'h44] !== 32'h27) begin failures++; $display("FAIL stall_mem got=%h exp=27", mem[8'h44]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; logic e; logic [3:0] id; int lat;
    bit seen; int wr0, rsp0;
    mem_wr_ready = 1'b0;
    send_req(FN_ADD, 32'h120, 32'd2, 4'h7);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); if (mem_wr_valid) seen = 1'b1; end
    checks++; if (!seen) begin failures++; $display("FAIL rmid_wr_timeout got=none exp=mem_wr_valid"); end
    wr0 = wr_cnt; rsp0 = rsp_cnt;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mem_wr_valid !== 1'b0) begin failures++; $display("FAIL rmid_wr_drop got=%b exp=0", mem_wr_valid); end
    rst = 1'b1; mem_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 2'b01) begin failures++; $display("FAIL rmid_idle got=%b exp=01", {rsp_valid, req_ready}); end
    checks++; if ((rsp_cnt - rsp0) + (wr_cnt - wr0) != 0) begin failures++; $display("FAIL rmid_no_rsp got=%0d exp=0", (rsp_cnt - rsp0) + (wr_cnt - wr0)); end
    checks++; if (mem[8'h48] !== 32'h1) begin failures++; $display("FAIL rmid_mem got=%h exp=1", mem[8'h48]); end
    run_req(FN_ADD, 32'h120, 32'd2, 4'h6, r, e, id, lat);
    checks++; if ({r, id, e} !== {32'h1, 4'h6, 1'b0}) begin failures++; $display("FAIL rmid_next got=%h/%h/%b exp=1/6/0", r, id, e); end
    checks++; if (mem[8'h48] !== 32'h3) begin failures++; $display("FAIL rmid_next_mem got=%h exp=3", mem[8'h48]); end
  endtask

  initial begin
    test_reset();
    test_amoadd();
    test_lr_sc();
    test_sc_fail();
    test_misaligned();
    test_stalls();
    test_reset_mid();
    checks++;
    if (multi_cnt != 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", multi_cnt); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
